// File: rtl/axis_conv_in_fifo_if.sv
// Beat bundle between the input-pipe stage and the conv engine: handshake, tlast, tuser,
// pixel and weight payloads. Modports are named from the point of view of the module using them.
interface axis_conv_in_fifo_if #(
    parameter int unsigned PIX_W       = 128,
    parameter int unsigned WGT_W       = 256,
    parameter int unsigned TUSER_WIDTH = 16
);
    logic                   tvalid;
    logic                   tready;
    logic                   tlast;
    logic [TUSER_WIDTH-1:0] tuser;
    logic [PIX_W-1:0]       pixels_tdata;
    logic [WGT_W-1:0]       weights_tdata;

    modport master (
        output tvalid, tlast, tuser, pixels_tdata, weights_tdata,
        input  tready
    );

    modport slave (
        input  tvalid, tlast, tuser, pixels_tdata, weights_tdata,
        output tready
    );
endinterface

// File: rtl/axis_conv_in_fifo.sv
// Elastic FIFO between input pipe and conv engine; counts delivered packets.
// Optional AXIS_CONV_IN_FIFO_STATS_EN adds max_count and stall_cycles outputs.
module axis_conv_in_fifo #(
    parameter int unsigned            UNITS       = 8,
    parameter int unsigned            COPIES      = 2,
    parameter int unsigned            CORES       = 4,
    parameter int unsigned            MEMBERS     = 8,
    parameter int unsigned            WORD_WIDTH  = 8,
    parameter int unsigned            TUSER_WIDTH = 16,
    parameter int unsigned            I_IS_CONFIG = 7,
    parameter logic [TUSER_WIDTH-1:0] GATED_MASK  = 16'h0F00,
    parameter int unsigned            DEPTH       = 4
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    axis_conv_in_fifo_if.slave       s_axis,
    axis_conv_in_fifo_if.master      m_axis,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              packets_out
`ifdef AXIS_CONV_IN_FIFO_STATS_EN
    ,
    output logic [$clog2(DEPTH):0]   max_count,
    output logic [31:0]              stall_cycles
`endif
);
    localparam int unsigned PIX_W = COPIES * WORD_WIDTH * UNITS;
    localparam int unsigned WGT_W = WORD_WIDTH * CORES * MEMBERS;
    localparam int unsigned ENT_W = 1 + TUSER_WIDTH + WGT_W + PIX_W;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    // The config flag must reach the engine even when no beat is valid.
    localparam logic [TUSER_WIDTH-1:0] MASK =
        GATED_MASK & ~(TUSER_WIDTH'(1) << I_IS_CONFIG);

    logic [ENT_W-1:0]       r_mem [DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_count;
    logic [CNT_W-1:0]       w_count_d;
    logic [15:0]            r_packets;
    logic                   w_tready;
    logic                   w_tvalid;
    logic                   w_push;
    logic                   w_pop;
    logic [ENT_W-1:0]       w_rd_entry;
    logic [TUSER_WIDTH-1:0] w_rd_tuser;

    assign w_tready   = aresetn && (r_count != FULL);
    assign w_tvalid   = aresetn && (r_count != '0);
    assign w_push     = s_axis.tvalid && w_tready;
    assign w_pop      = w_tvalid && m_axis.tready;
    assign w_rd_entry = r_mem[r_rd_ptr];
    assign w_rd_tuser = w_rd_entry[ENT_W-2 -: TUSER_WIDTH];

    assign s_axis.tready        = w_tready;
    assign m_axis.tvalid        = w_tvalid;
    assign m_axis.tlast         = w_rd_entry[ENT_W-1];
    assign m_axis.tuser         = w_rd_tuser & ~(MASK & {TUSER_WIDTH{~w_tvalid}});
    assign m_axis.weights_tdata = w_rd_entry[PIX_W +: WGT_W];
    assign m_axis.pixels_tdata  = w_rd_entry[0 +: PIX_W];
    assign count                = r_count;
    assign packets_out          = r_packets;

    always_comb begin
        w_count_d = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_d = r_count + CNT_W'(1);
            2'b01:   w_count_d = r_count - CNT_W'(1);
            default: w_count_d = r_count;
        endcase
    end

    // Payload storage carries no reset; occupancy alone says what is live.
    always_ff @(posedge aclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {s_axis.tlast, s_axis.tuser, s_axis.weights_tdata,
                                s_axis.pixels_tdata};
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_packets <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= w_count_d;
            if (w_pop && w_rd_entry[ENT_W-1]) r_packets <= r_packets + 16'd1;
        end
    end

`ifdef AXIS_CONV_IN_FIFO_STATS_EN
    logic [CNT_W-1:0] r_max_count;
    logic [31:0]      r_stall_cycles;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_max_count    <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (w_count_d > r_max_count) r_max_count <= w_count_d;
            if (w_tvalid && !m_axis.tready && (r_stall_cycles != 32'hFFFF_FFFF)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
        end
    end

    assign max_count    = r_max_count;
    assign stall_cycles = r_stall_cycles;
`endif
endmodule

// File: tb/tb_axis_conv_in_fifo.sv
// Randomized bench for axis_conv_in_fifo: a queue model predicts every output each cycle,
// and directed phases pin reset, full, empty-gating and packet-count behaviour with literals.
module tb_axis_conv_in_fifo;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PIX_W = 2 * 8 * 8;
    localparam int unsigned WGT_W = 8 * 4 * 8;
    localparam logic [15:0] MASK  = 16'h0F00;
    localparam int unsigned NRAND = 2000;

    typedef struct {
        logic             last;
        logic [15:0]      tuser;
        logic [WGT_W-1:0] w;
        logic [PIX_W-1:0] p;
    } beat_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic [2:0]  count;
    logic [15:0] packets_out;
`ifdef AXIS_CONV_IN_FIFO_STATS_EN
    logic [2:0]  max_count;
    logic [31:0] stall_cycles;
`endif

    axis_conv_in_fifo_if #(.PIX_W(PIX_W), .WGT_W(WGT_W), .TUSER_WIDTH(16)) s_if ();
    axis_conv_in_fifo_if #(.PIX_W(PIX_W), .WGT_W(WGT_W), .TUSER_WIDTH(16)) m_if ();

    axis_conv_in_fifo #(
        .UNITS(8), .COPIES(2), .CORES(4), .MEMBERS(8), .WORD_WIDTH(8), .TUSER_WIDTH(16),
        .I_IS_CONFIG(7), .GATED_MASK(16'h0F00), .DEPTH(DEPTH)
    ) dut (
        .aclk        (clk),
        .aresetn     (rstn),
        .s_axis      (s_if),
        .m_axis      (m_if),
        .count       (count),
        .packets_out (packets_out)
`ifdef AXIS_CONV_IN_FIFO_STATS_EN
        ,
        .max_count   (max_count),
        .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    beat_t cur;
    logic  s_valid;
    logic  m_ready;
    assign s_if.tvalid        = s_valid;
    assign s_if.tlast         = cur.last;
    assign s_if.tuser         = cur.tuser;
    assign s_if.weights_tdata = cur.w;
    assign s_if.pixels_tdata  = cur.p;
    assign m_if.tready        = m_ready;

    int    n_tests = 0;
    int    n_fail  = 0;
    bit    chk_en  = 1'b0;

    // Model state
    beat_t       q[$];
    bit          m_push = 1'b0;
    bit          m_pop  = 1'b0;
    logic [15:0] m_pk   = '0;
    int          m_npop = 0;
    int          m_max  = 0;
    logic [31:0] m_stall = '0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic beat_t mk(input int seq, input bit last, input logic [15:0] tu);
        beat_t b;
        b.last  = last;
        b.tuser = tu;
        for (int i = 0; i < PIX_W / 32; i++) b.p[i*32 +: 32] = $urandom();
        for (int i = 0; i < WGT_W / 32; i++) b.w[i*32 +: 32] = $urandom();
        b.p[31:0] = 32'(seq);
        return b;
    endfunction

    // Reference model: a queue of accepted beats, updated at each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            if (!rstn) begin
                q.delete();
                m_push = 1'b0;
                m_pop  = 1'b0;
                m_pk   = '0;
                m_npop = 0;
                m_max  = 0;
                m_stall = '0;
            end else begin
                m_pop  = (q.size() != 0) && m_ready;
                m_push = s_valid && (q.size() < DEPTH);
                if ((q.size() != 0) && !m_ready && (m_stall != 32'hFFFF_FFFF)) m_stall++;
                if (m_pop) begin
                    if (q[0].last) m_pk++;
                    m_npop++;
                    void'(q.pop_front());
                end
                if (m_push) q.push_back(cur);
                if (q.size() > m_max) m_max = q.size();
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("tready", s_if.tready, rstn && (q.size() != DEPTH));
                chk("tvalid", m_if.tvalid, rstn && (q.size() != 0));
                chk("count", count, q.size());
                chk("packets_out", packets_out, m_pk);
`ifdef AXIS_CONV_IN_FIFO_STATS_EN
                chk("max_count", max_count, m_max);
                chk("stall_cycles", stall_cycles, m_stall);
`endif
                if (rstn && (q.size() != 0)) begin
                    chk("tlast", m_if.tlast, q[0].last);
                    chk("tuser", m_if.tuser, q[0].tuser);
                    chk("pixels", m_if.pixels_tdata, q[0].p);
                    chk("weights", m_if.weights_tdata, q[0].w);
                end else begin
                    chk("tuser_gated", m_if.tuser & MASK, 16'h0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (q.size() == 0) break;
            tick();
        end
        chk(name, q.size(), 0);
    endtask

    int seq;
    int sent;
    int cyc;

    initial begin
        // Reset with valid held high
        rstn    = 1'b0;
        m_ready = 1'b0;
        cur     = mk(1, 1'b0, 16'h0F80);
        cur.p   = '0;
        cur.p[0] = 1'b1;
        s_valid = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        @(negedge clk);
        chk("rst_tready", s_if.tready, 1'b0);
        chk("rst_tvalid", m_if.tvalid, 1'b0);
        chk("rst_count", count, 3'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("rel_tready", s_if.tready, 1'b1);
        tick();
        s_valid = 1'b0;
        @(negedge clk);
        chk("first_tvalid", m_if.tvalid, 1'b1);
        chk("first_tuser", m_if.tuser, 16'h0F80);
        chk("first_pixels", m_if.pixels_tdata, 128'h1);
        drain("drain_first");

        // Fill to full with the consumer stalled
        m_ready = 1'b0;
        seq     = 1;
        cur     = mk(seq, 1'b0, 16'(seq));
        s_valid = 1'b1;
        repeat (6) begin
            tick();
            if (m_push) begin
                seq++;
                cur = mk(seq, 1'b0, 16'(seq));
            end
        end
        @(negedge clk);
        chk("full_count", count, 3'd4);
        chk("full_tready", s_if.tready, 1'b0);
        chk("full_head", m_if.pixels_tdata[31:0], 32'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        m_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("tready_after_pop", s_if.tready, 1'b1);
        chk("second_head", m_if.pixels_tdata[31:0], 32'd2);
        drain("drain_full");

        // Continuous streaming
        seq     = 1;
        cur     = mk(seq, 1'b0, 16'($urandom_range(0, 65535)));
        s_valid = 1'b1;
        m_ready = 1'b1;
        while (seq <= 100) begin
            tick();
            if (m_push) begin
                seq++;
                cur = mk(seq, (seq % 9) == 0, 16'($urandom_range(0, 65535)));
            end
            if (seq == 50) begin
                @(negedge clk);
                chk("stream_count", count, 3'd1);
                @(posedge clk);
                #1;
                if (m_push) begin
                    seq++;
                    cur = mk(seq, (seq % 9) == 0, 16'($urandom_range(0, 65535)));
                end
            end
        end
        drain("drain_stream");

        // Gating on an empty FIFO: every slot holds 16'hFFFF
        m_ready = 1'b0;
        cur     = mk(0, 1'b1, 16'hFFFF);
        s_valid = 1'b1;
        repeat (4) tick();
        drain("drain_ffff");
        @(negedge clk);
        chk("empty_tvalid", m_if.tvalid, 1'b0);
        chk("empty_tuser", m_if.tuser, 16'hF0FF);

        // Reset with three beats inside
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        seq     = 1000;
        cur     = mk(seq, 1'b1, 16'h1234);
        s_valid = 1'b1;
        repeat (3) begin
            tick();
            seq++;
            cur = mk(seq, 1'b1, 16'h1234);
        end
        s_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_count", count, 3'd3);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        tick();
        @(negedge clk);
        chk("mid_rst_count", count, 3'd0);
        chk("mid_rst_tvalid", m_if.tvalid, 1'b0);
        chk("mid_rst_packets", packets_out, 16'd0);
        @(posedge clk);
        #1;
        rstn    = 1'b1;
        m_ready = 1'b1;
        seq     = 2000;
        cur     = mk(seq, 1'b0, 16'h00AA);
        s_valid = 1'b1;
        repeat (5) begin
            tick();
            if (m_push) begin
                seq++;
                cur = mk(seq, 1'b0, 16'h00AA);
            end
        end
        drain("drain_post_rst");

        // Random valid/ready from a clean reset
        s_valid = 1'b0;
        rstn    = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        sent = 0;
        cur  = mk(1, 1'b0, 16'($urandom_range(0, 65535)));
        s_valid = 1'($urandom_range(0, 1));
        m_ready = 1'($urandom_range(0, 1));
        cyc = 0;
        while ((m_npop < NRAND) && (cyc < 30000)) begin
            tick();
            cyc++;
            if (m_push) begin
                sent++;
                if (sent < NRAND) begin
                    cur = mk(sent + 1, ((sent + 1) % 9) == 0, 16'($urandom_range(0, 65535)));
                end
            end
            s_valid = (sent < NRAND) && 1'($urandom_range(0, 1));
            m_ready = 1'($urandom_range(0, 1));
        end
        chk("random_popped", m_npop, NRAND);
        @(negedge clk);
        chk("random_packets", packets_out, 16'd222);
        chk("random_empty", count, 3'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
